// File: rtl/alu_rs_pkg.sv
// Shared widths, ALU opcodes and slot bookkeeping types for the ALU reservation station.
package alu_rs_pkg;

   localparam int unsigned ENTRIES      = 4;
   localparam int unsigned ALU_RS_WIDTH = $clog2(ENTRIES);
   localparam int unsigned TAG_WIDTH    = 4;
   localparam int unsigned DATA_WIDTH   = 32;
   localparam int unsigned OP_W         = 5;

   typedef enum logic [OP_W-1:0] {
      AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra, AluSlt, AluSltu
   } alu_op_e;

   typedef enum logic [1:0] {SlotFree, SlotWait, SlotReady, SlotIssued} slot_state_e;

   typedef struct packed {
      logic [OP_W-1:0]       op;
      logic [TAG_WIDTH-1:0]  tag;
      logic                  j_rdy;
      logic                  k_rdy;
      logic [DATA_WIDTH-1:0] vj;
      logic [DATA_WIDTH-1:0] vk;
      logic [TAG_WIDTH-1:0]  qj;
      logic [TAG_WIDTH-1:0]  qk;
   } rs_entry_t;

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop, slot release and ALU issue signals of the ALU reservation station.
interface alu_rs_if;
   import alu_rs_pkg::*;

   logic                    dispValid;
   logic                    dispReady;
   logic [OP_W-1:0]         dispOp;
   logic [TAG_WIDTH-1:0]    dispTag;
   logic                    dispJRdy;
   logic                    dispKRdy;
   logic [DATA_WIDTH-1:0]   dispVj;
   logic [DATA_WIDTH-1:0]   dispVk;
   logic [TAG_WIDTH-1:0]    dispQj;
   logic [TAG_WIDTH-1:0]    dispQk;
   logic                    cdbValid;
   logic [TAG_WIDTH-1:0]    cdbTag;
   logic [DATA_WIDTH-1:0]   cdbData;
   logic                    freeValid;
   logic [ALU_RS_WIDTH-1:0] freeRSNum;
   logic                    aluReady;
   logic                    aluValid;
   logic [OP_W-1:0]         aluOp;
   logic [DATA_WIDTH-1:0]   aluA;
   logic [DATA_WIDTH-1:0]   aluB;
   logic [TAG_WIDTH-1:0]    aluTag;
   logic [ALU_RS_WIDTH-1:0] aluRSNum;

   modport master (
      output dispValid, dispOp, dispTag, dispJRdy, dispKRdy, dispVj, dispVk, dispQj, dispQk,
      output cdbValid, cdbTag, cdbData, freeValid, freeRSNum, aluReady,
      input  dispReady, aluValid, aluOp, aluA, aluB, aluTag, aluRSNum
   );

   modport slave (
      input  dispValid, dispOp, dispTag, dispJRdy, dispKRdy, dispVj, dispVk, dispQj, dispQk,
      input  cdbValid, cdbTag, cdbData, freeValid, freeRSNum, aluReady,
      output dispReady, aluValid, aluOp, aluA, aluB, aluTag, aluRSNum
   );

endinterface

// File: rtl/alu_rs_pick.sv
// Lowest-index priority encoder used for the FREE-slot and READY-slot searches.
module alu_rs_pick #(
   parameter int unsigned NumReq = 4,
   localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic [NumReq-1:0] req,
   output logic              found,
   output logic [IdxW-1:0]   idx
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = int'(NumReq) - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = IdxW'(i);
         end
      end
   end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch, CDB wake-up, in-order-by-slot issue and release.
// Optional same-edge CDB capture at dispatch is enabled by defining ALU_RS_BYPASS_EN.
module alu_rs
   import alu_rs_pkg::*;
(
   input logic     clk,
   input logic     rst,
   input logic     flush,
   alu_rs_if.slave bus
);

   slot_state_e             st_q  [ENTRIES];
   slot_state_e             st_d  [ENTRIES];
   rs_entry_t               ent_q [ENTRIES];
   rs_entry_t               ent_d [ENTRIES];
   logic [ENTRIES-1:0]      free_vec;
   logic [ENTRIES-1:0]      ready_vec;
   logic                    free_found;
   logic                    ready_found;
   logic [ALU_RS_WIDTH-1:0] free_idx;
   logic [ALU_RS_WIDTH-1:0] ready_idx;
   logic                    disp_fire;
   rs_entry_t               disp_ent;

   logic                    alu_valid_q, alu_valid_d;
   logic [OP_W-1:0]         alu_op_q, alu_op_d;
   logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
   logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
   logic [TAG_WIDTH-1:0]    alu_tag_q, alu_tag_d;
   logic [ALU_RS_WIDTH-1:0] alu_rs_num_q, alu_rs_num_d;

   always_comb begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
         free_vec[i]  = (st_q[i] == SlotFree);
         ready_vec[i] = (st_q[i] == SlotReady);
      end
   end

   alu_rs_pick #(.NumReq(ENTRIES)) u_pick_free (
      .req   (free_vec),
      .found (free_found),
      .idx   (free_idx)
   );

   alu_rs_pick #(.NumReq(ENTRIES)) u_pick_ready (
      .req   (ready_vec),
      .found (ready_found),
      .idx   (ready_idx)
   );

`ifdef ALU_RS_BYPASS_EN
   assign bus.dispReady = free_found && !rst;
`else
   // Without capture at dispatch, a broadcast in flight would be lost to the new slot.
   assign bus.dispReady = free_found && !rst && !bus.cdbValid;
`endif

   assign disp_fire = bus.dispValid && bus.dispReady;

   always_comb begin
      disp_ent.op    = bus.dispOp;
      disp_ent.tag   = bus.dispTag;
      disp_ent.j_rdy = bus.dispJRdy;
      disp_ent.k_rdy = bus.dispKRdy;
      disp_ent.vj    = bus.dispVj;
      disp_ent.vk    = bus.dispVk;
      disp_ent.qj    = bus.dispQj;
      disp_ent.qk    = bus.dispQk;
`ifdef ALU_RS_BYPASS_EN
      if (!bus.dispJRdy && bus.cdbValid && (bus.dispQj == bus.cdbTag)) begin
         disp_ent.j_rdy = 1'b1;
         disp_ent.vj    = bus.cdbData;
      end
      if (!bus.dispKRdy && bus.cdbValid && (bus.dispQk == bus.cdbTag)) begin
         disp_ent.k_rdy = 1'b1;
         disp_ent.vk    = bus.cdbData;
      end
`endif
   end

   always_comb begin
      st_d         = st_q;
      ent_d        = ent_q;
      alu_valid_d  = 1'b0;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_tag_d    = alu_tag_q;
      alu_rs_num_d = alu_rs_num_q;

      if (bus.cdbValid) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            if (st_q[i] == SlotWait) begin
               if (!ent_q[i].j_rdy && (ent_q[i].qj == bus.cdbTag)) begin
                  ent_d[i].j_rdy = 1'b1;
                  ent_d[i].vj    = bus.cdbData;
               end
               if (!ent_q[i].k_rdy && (ent_q[i].qk == bus.cdbTag)) begin
                  ent_d[i].k_rdy = 1'b1;
                  ent_d[i].vk    = bus.cdbData;
               end
               if (ent_d[i].j_rdy && ent_d[i].k_rdy) begin
                  st_d[i] = SlotReady;
               end
            end
         end
      end

      if (bus.aluReady && ready_found) begin
         alu_valid_d       = 1'b1;
         alu_op_d          = ent_q[ready_idx].op;
         alu_a_d           = ent_q[ready_idx].vj;
         alu_b_d           = ent_q[ready_idx].vk;
         alu_tag_d         = ent_q[ready_idx].tag;
         alu_rs_num_d      = ready_idx;
         st_d[ready_idx]   = SlotIssued;
      end

      if (bus.freeValid && (st_q[bus.freeRSNum] == SlotIssued)) begin
         st_d[bus.freeRSNum] = SlotFree;
      end

      if (disp_fire) begin
         ent_d[free_idx] = disp_ent;
         st_d[free_idx]  = (disp_ent.j_rdy && disp_ent.k_rdy) ? SlotReady : SlotWait;
      end

      if (flush) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            st_d[i] = SlotFree;
         end
         alu_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            st_q[i]  <= SlotFree;
            ent_q[i] <= '0;
         end
         alu_valid_q  <= 1'b0;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_tag_q    <= '0;
         alu_rs_num_q <= '0;
      end else begin
         st_q         <= st_d;
         ent_q        <= ent_d;
         alu_valid_q  <= alu_valid_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_tag_q    <= alu_tag_d;
         alu_rs_num_q <= alu_rs_num_d;
      end
   end

   assign bus.aluValid = alu_valid_q;
   assign bus.aluOp    = alu_op_q;
   assign bus.aluA     = alu_a_q;
   assign bus.aluB     = alu_b_q;
   assign bus.aluTag   = alu_tag_q;
   assign bus.aluRSNum = alu_rs_num_q;

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: directed dispatch/CDB/release/flush vectors, issue monitor.
module tb_alu_rs;
   import alu_rs_pkg::*;

   typedef struct packed {
      logic [OP_W-1:0]         op;
      logic [DATA_WIDTH-1:0]   a;
      logic [DATA_WIDTH-1:0]   b;
      logic [TAG_WIDTH-1:0]    tag;
      logic [ALU_RS_WIDTH-1:0] rs;
   } iss_t;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic flush = 1'b0;
   iss_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   alu_rs_if bus ();

   alu_rs dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic iss_t mk(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                               input int tag, input int rs);
      iss_t r;
      r.op  = op;
      r.a   = a;
      r.b   = b;
      r.tag = TAG_WIDTH'(tag);
      r.rs  = ALU_RS_WIDTH'(rs);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic disp(input alu_op_e op, input int tag, input logic jr, input logic [31:0] vj,
                       input int qj, input logic kr, input logic [31:0] vk, input int qk);
      bus.dispValid = 1'b1;
      bus.dispOp    = op;
      bus.dispTag   = TAG_WIDTH'(tag);
      bus.dispJRdy  = jr;
      bus.dispVj    = vj;
      bus.dispQj    = TAG_WIDTH'(qj);
      bus.dispKRdy  = kr;
      bus.dispVk    = vk;
      bus.dispQk    = TAG_WIDTH'(qk);
      tick();
      bus.dispValid = 1'b0;
   endtask

   task automatic cdb(input int tag, input logic [31:0] data);
      bus.cdbValid = 1'b1;
      bus.cdbTag   = TAG_WIDTH'(tag);
      bus.cdbData  = data;
      tick();
      bus.cdbValid = 1'b0;
   endtask

   task automatic release_slot(input int rs);
      bus.freeValid = 1'b1;
      bus.freeRSNum = ALU_RS_WIDTH'(rs);
      tick();
      bus.freeValid = 1'b0;
   endtask

   // Issue monitor: every aluValid cycle must match the oldest expected issue.
   initial begin
      iss_t got;
      iss_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.aluValid) begin
            got = '{op: bus.aluOp, a: bus.aluA, b: bus.aluB, tag: bus.aluTag, rs: bus.aluRSNum};
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL issue: unexpected aluValid op=%0d a=%0h b=%0h tag=%0d rs=%0d",
                        got.op, got.a, got.b, got.tag, got.rs);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  n_bad++;
                  $display("FAIL issue: got op=%0d a=%0h b=%0h tag=%0d rs=%0d want op=%0d a=%0h b=%0h tag=%0d rs=%0d",
                           got.op, got.a, got.b, got.tag, got.rs, e.op, e.a, e.b, e.tag, e.rs);
               end
            end
         end
      end
   end

   initial begin
      bus.dispValid = 1'b0;
      bus.dispOp    = '0;
      bus.dispTag   = '0;
      bus.dispJRdy  = 1'b0;
      bus.dispKRdy  = 1'b0;
      bus.dispVj    = '0;
      bus.dispVk    = '0;
      bus.dispQj    = '0;
      bus.dispQk    = '0;
      bus.cdbValid  = 1'b0;
      bus.cdbTag    = '0;
      bus.cdbData   = '0;
      bus.freeValid = 1'b0;
      bus.freeRSNum = '0;
      bus.aluReady  = 1'b1;

      // Reset
      tick();
      tick();
      check("rst_dispready", 32'(bus.dispReady), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_aluvalid", 32'(bus.aluValid), 32'd0);
      check("rst_aluop", 32'(bus.aluOp), 32'd0);
      check("rst_alua", bus.aluA, 32'd0);
      check("rst_alub", bus.aluB, 32'd0);
      check("rst_alutag", 32'(bus.aluTag), 32'd0);
      check("rst_rsnum", 32'(bus.aluRSNum), 32'd0);
      check("post_rst_dispready", 32'(bus.dispReady), 32'd1);

      // Both operands valid: issue two cycles after dispatch
      exp_q.push_back(mk(AluAdd, 32'd5, 32'd7, 3, 0));
      disp(AluAdd, 3, 1'b1, 32'd5, 0, 1'b1, 32'd7, 0);
      check("s1_lat1", 32'(bus.aluValid), 32'd0);
      tick();
      check("s1_lat2", 32'(bus.aluValid), 32'd1);
      release_slot(0);

      // Pending j on tag 2; wrong tag and a tag matching only the valid k must not wake it
      disp(AluSub, 4, 1'b0, 32'd0, 2, 1'b1, 32'd1, 0);
      cdb(9, 32'h99);
      cdb(0, 32'hdead);
      tick();
      check("s2_nowake", 32'(bus.aluValid), 32'd0);
      exp_q.push_back(mk(AluSub, 32'h10, 32'd1, 4, 0));
      cdb(2, 32'h10);
      check("s2_wake_lat", 32'(bus.aluValid), 32'd0);
      tick();
      check("s2_issue", 32'(bus.aluValid), 32'd1);
      release_slot(0);

      // Fill all slots with pending operands
      disp(AluAnd, 8, 1'b0, 32'd0, 12, 1'b1, 32'd1, 0);
      disp(AluOr, 9, 1'b0, 32'd0, 12, 1'b1, 32'd2, 0);
      disp(AluXor, 10, 1'b0, 32'd0, 14, 1'b1, 32'd3, 0);
      disp(AluSll, 11, 1'b0, 32'd0, 12, 1'b1, 32'd4, 0);
      check("s3_full", 32'(bus.dispReady), 32'd0);
      exp_q.push_back(mk(AluXor, 32'h22, 32'd3, 10, 2));
      cdb(14, 32'h22);
      tick();
      release_slot(2);
      check("s3_reuse", 32'(bus.dispReady), 32'd1);
      exp_q.push_back(mk(AluAdd, 32'h40, 32'd2, 12, 2));
      disp(AluAdd, 12, 1'b1, 32'h40, 0, 1'b1, 32'd2, 0);
      tick();
      check("s3_slot", 32'(bus.aluRSNum), 32'd2);
      release_slot(2);

      // Three slots wake on one edge; held back by aluReady, then issue lowest first
      bus.aluReady = 1'b0;
      exp_q.push_back(mk(AluAnd, 32'h30, 32'd1, 8, 0));
      exp_q.push_back(mk(AluOr, 32'h30, 32'd2, 9, 1));
      exp_q.push_back(mk(AluSll, 32'h30, 32'd4, 11, 3));
      cdb(12, 32'h30);
      tick();
      tick();
      check("s4_hold", 32'(bus.aluValid), 32'd0);
      bus.aluReady = 1'b1;
      tick();
      check("s4_first", 32'(bus.aluRSNum), 32'd0);
      tick();
      check("s4_second", 32'(bus.aluRSNum), 32'd1);
      tick();
      check("s4_third", 32'(bus.aluRSNum), 32'd3);
      release_slot(0);
      release_slot(1);
      release_slot(3);

      // Dispatch concurrent with the producing broadcast
`ifdef ALU_RS_BYPASS_EN
      exp_q.push_back(mk(AluSra, 32'd3, 32'h55, 5, 0));
      bus.cdbValid = 1'b1;
      bus.cdbTag   = TAG_WIDTH'(6);
      bus.cdbData  = 32'h55;
      disp(AluSra, 5, 1'b1, 32'd3, 0, 1'b0, 32'd0, 6);
      bus.cdbValid = 1'b0;
      tick();
      check("s5_bypass", 32'(bus.aluValid), 32'd1);
      release_slot(0);
`else
      bus.cdbValid  = 1'b1;
      bus.cdbTag    = TAG_WIDTH'(6);
      bus.cdbData   = 32'h55;
      bus.dispValid = 1'b1;
      bus.dispOp    = AluSra;
      bus.dispTag   = TAG_WIDTH'(5);
      bus.dispJRdy  = 1'b1;
      bus.dispVj    = 32'd3;
      bus.dispKRdy  = 1'b0;
      bus.dispQk    = TAG_WIDTH'(6);
      #1;
      check("s5_block", 32'(bus.dispReady), 32'd0);
      tick();
      bus.cdbValid  = 1'b0;
      bus.dispValid = 1'b0;
      tick();
      tick();
`endif

      // Flush with busy slots, racing a dispatch, a release and a ready issue
      bus.aluReady = 1'b0;
      disp(AluAdd, 1, 1'b0, 32'd0, 1, 1'b1, 32'd0, 0);
      disp(AluSub, 2, 1'b0, 32'd0, 1, 1'b1, 32'd0, 0);
      disp(AluOr, 3, 1'b1, 32'h11, 0, 1'b1, 32'h22, 0);
      flush         = 1'b1;
      bus.aluReady  = 1'b1;
      bus.freeValid = 1'b1;
      bus.freeRSNum = '0;
      disp(AluAnd, 7, 1'b1, 32'h1, 0, 1'b1, 32'h2, 0);
      flush         = 1'b0;
      bus.freeValid = 1'b0;
      check("s6_flush_valid", 32'(bus.aluValid), 32'd0);
      check("s6_ready", 32'(bus.dispReady), 32'd1);
      cdb(1, 32'h77);
      tick();
      tick();
      tick();
      exp_q.push_back(mk(AluXor, 32'hf0, 32'h0f, 6, 0));
      disp(AluXor, 6, 1'b1, 32'hf0, 0, 1'b1, 32'h0f, 0);
      tick();
      check("s6_after", 32'(bus.aluRSNum), 32'd0);
      release_slot(0);
      tick();
      tick();
      tick();
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_rs.md
# alu_rs

ALU reservation station: the consuming end of the common data bus. Accepts dispatched ALU instructions, snoops CDB broadcasts to capture pending operands by ROB tag, and issues ready entries to the ALU. The ALU's CDB completion, carrying the RS entry number, releases the slot. Sits between dispatch and the ALU; takes the CDB broadcast (tag, data) and completion (RS number) outputs.

## Interface
- ENTRIES, 4, number of RS slots; power of two, equals 2^`aluRSWidth
- OP_W, 5, ALU opcode width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  ROB mispredict flush; empties the station
- dispValid  in  1  dispatch offers an instruction
- dispReady  out  1  a FREE slot exists and dispatch may be accepted
- dispOp  in  OP_W  ALU opcode
- dispTag  in  `tagWidth  destination ROB tag
- dispJRdy / dispKRdy  in  1  operand j / k value already valid
- dispVj / dispVk  in  `dataWidth  operand values, meaningful when the matching Rdy bit is 1
- dispQj / dispQk  in  `tagWidth  producer tags, meaningful when the matching Rdy bit is 0
- cdbValid  in  1  CDB broadcast valid (aluFinish)
- cdbTag  in  `tagWidth  broadcast ROB tag
- cdbData  in  `dataWidth  broadcast value
- freeValid  in  1  ALU completion releases a slot
- freeRSNum  in  `aluRSWidth  slot to release
- aluReady  in  1  ALU can accept an operation
- aluValid  out  1  issued operation valid, one-cycle pulse
- aluOp  out  OP_W; aluA, aluB  out  `dataWidth; aluTag  out  `tagWidth; aluRSNum  out  `aluRSWidth  issued operation fields

## Operation
- Per-slot states: FREE → WAIT (operand pending) or READY → ISSUED → FREE.
- Dispatch: on an edge with dispValid && dispReady, write into the lowest-index FREE slot. The slot enters READY if both operands are valid after bypass, otherwise WAIT.
- Wake-up: each edge with cdbValid, every WAIT slot whose pending Qj/Qk equals cdbTag latches cdbData and sets that Rdy bit. A slot with both bits set moves to READY on the same edge.
- Issue: on an edge with aluReady and at least one READY slot, register the lowest-index READY slot into the alu* outputs and move it to ISSUED. aluValid is high for exactly the next cycle.
- Release: on an edge with freeValid, slot freeRSNum goes ISSUED → FREE. freeValid on a non-ISSUED slot is ignored.
- Flush: every slot goes FREE and aluValid goes 0. Flush takes priority over dispatch, wake-up, issue and release in the same edge.
- dispReady = any slot FREE (pre-edge state) && !rst. Release and dispatch in the same edge cannot target the same slot.
- Only pending operands compare against cdbTag. A valid operand is never overwritten.

## Timing
- Reset: all slots FREE; aluValid, aluOp, aluA, aluB, aluTag and aluRSNum are 0; dispReady is 0 while rst is high.
- Dispatch with both operands valid → aluValid 2 cycles later, given aluReady.
- CDB broadcast at edge N completing a slot → that slot issues at edge N+1 at the earliest.
- Maximum throughput is one issue per cycle.
- A slot is reusable the cycle after its release edge.

## Configuration
- ALU_RS_BYPASS_EN defined:
  - A dispatched operand with Rdy=0 whose Q equals cdbTag while cdbValid is high takes cdbData at the dispatch edge.
  - That operand counts as valid.
- ALU_RS_BYPASS_EN undefined:
  - dispReady is additionally forced to 0 whenever cdbValid is high.
  - This ensures no broadcast is missed between rename and slot write.

## Structure
- `aluRSWidth, `tagWidth, `dataWidth and the ALU opcode encodings live in defines.v.
- The slot state encoding (FREE/WAIT/READY/ISSUED) also goes in defines.v.
- One sub-module, alu_rs_pick: a lowest-index priority encoder. It is instantiated twice: once for the FREE search and once for the READY search.

## Test plan
- Dispatch op=ADD, tag=3, Vj=5, Vk=7, both valid, aluReady=1 → two cycles later aluValid=1, aluA=5, aluB=7, aluTag=3, aluRSNum=0.
- Dispatch tag=4 with Qj=2 pending, then cdbValid tag=2 data=0x10 → aluA=0x10 issued the cycle after wake-up; a broadcast of tag=9 does not wake it.
- Fill all 4 slots with pending operands → dispReady=0; freeValid on slot 2 after it issues → dispReady=1 and the next dispatch lands in slot 2.
- Two slots become READY on the same edge → slot 0 issues first, slot 1 on the next aluReady edge; hold aluReady=0 → no aluValid.
- Same-cycle dispatch with Qk=6 and CDB tag=6 data=0x55 → with ALU_RS_BYPASS_EN, aluB=0x55 issued; without it, dispReady=0 in that cycle.
- Flush with 3 busy slots, concurrent with dispatch and freeValid → all FREE, aluValid=0, the dispatch is dropped, dispReady=1 next cycle.
